// File: rtl/sd_xfer_sched_if.sv
// Host-request, engine-pin and status bundle for the SD transaction scheduler.
// The scheduler takes the slave side; the host/engine environment takes the master side.
interface sd_xfer_sched_if;
  logic wr_req;
  logic rd_req;
  logic err_clr;
  logic init_o;
  logic init_CSn;
  logic init_MOSI;
  logic wr_ok;
  logic wr_CSn;
  logic wr_MOSI;
  logic rd_ok;
  logic rd_CSn;
  logic rd_MOSI;
  logic init_rst_n;
  logic wr_rst_n;
  logic rd_rst_n;
  logic write_seq;
  logic read_seq;
  logic SD_CSn;
  logic SD_MOSI;
  logic init_done;
  logic busy;
  logic wr_done;
  logic rd_done;
  logic err;

  modport slave (
    input  wr_req, rd_req, err_clr,
    input  init_o, init_CSn, init_MOSI,
    input  wr_ok, wr_CSn, wr_MOSI,
    input  rd_ok, rd_CSn, rd_MOSI,
    output init_rst_n, wr_rst_n, rd_rst_n,
    output write_seq, read_seq, SD_CSn, SD_MOSI,
    output init_done, busy, wr_done, rd_done, err
  );

  modport master (
    output wr_req, rd_req, err_clr,
    output init_o, init_CSn, init_MOSI,
    output wr_ok, wr_CSn, wr_MOSI,
    output rd_ok, rd_CSn, rd_MOSI,
    input  init_rst_n, wr_rst_n, rd_rst_n,
    input  write_seq, read_seq, SD_CSn, SD_MOSI,
    input  init_done, busy, wr_done, rd_done, err
  );
endinterface

// File: rtl/sd_xfer_sched.sv
// SD SPI transaction scheduler: runs card init, then arbitrates block writes and
// reads onto the card bus, owning CSn/MOSI and holding idle engines in reset.
module sd_xfer_sched #(
  parameter int INIT_TO = 65535,
  parameter int XFER_TO = 4095,
  parameter int CNT_W   = 16
) (
  input  logic           SD_CK,
  input  logic           rst,
  sd_xfer_sched_if.slave bus
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE,
    S_WR_ARM, S_WR_SEQ, S_WR_WAIT,
    S_RD_ARM, S_RD_SEQ, S_RD_WAIT,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_INIT, SEL_WR, SEL_RD} sel_e;

  localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_TO);
  localparam logic [CNT_W-1:0] XFER_LIM = CNT_W'(XFER_TO);

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_lim;
  logic             pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic             last_wr_q, last_wr_d;
  logic             init_rst_n_q, init_rst_n_d;
  logic             wr_rst_n_q, wr_rst_n_d;
  logic             rd_rst_n_q, rd_rst_n_d;
  logic             write_seq_q, write_seq_d;
  logic             read_seq_q, read_seq_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;
  logic             err_q, err_d;
  logic             clr_wr, clr_rd, pick_wr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    pend_wr_d   = pend_wr_q;
    pend_rd_d   = pend_rd_q;
    last_wr_d   = last_wr_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    clr_wr      = 1'b0;
    clr_rd      = 1'b0;
    // On a tie, serve the opposite of whichever engine finished last.
    pick_wr     = pend_wr_q && (!pend_rd_q || !last_wr_q);
    cnt_lim     = (state_q == S_INIT) ? INIT_LIM : XFER_LIM;

    case (state_q)
      S_INIT: begin
        if (bus.init_o) begin
          init_done_d = 1'b1;
          sel_d       = SEL_NONE;
          state_d     = S_IDLE;
        end else if (cnt_q == INIT_LIM) begin
          state_d = S_ERR;
        end
      end
      S_IDLE: begin
        if (pick_wr) begin
          sel_d   = SEL_WR;
          state_d = S_WR_ARM;
        end else if (pend_rd_q) begin
          sel_d   = SEL_RD;
          state_d = S_RD_ARM;
        end
      end
      S_WR_ARM: state_d = S_WR_SEQ;
      S_WR_SEQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.wr_ok) begin
          wr_done_d = 1'b1;
          clr_wr    = 1'b1;
          last_wr_d = 1'b1;
          sel_d     = SEL_NONE;
          state_d   = S_IDLE;
        end else if (cnt_q == XFER_LIM) begin
          state_d = S_ERR;
        end
      end
      S_RD_ARM: state_d = S_RD_SEQ;
      S_RD_SEQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.rd_ok) begin
          rd_done_d = 1'b1;
          clr_rd    = 1'b1;
          last_wr_d = 1'b0;
          sel_d     = SEL_NONE;
          state_d   = S_IDLE;
        end else if (cnt_q == XFER_LIM) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (bus.err_clr) begin
          err_d       = 1'b0;
          init_done_d = 1'b0;
          sel_d       = SEL_INIT;
          state_d     = S_INIT;
        end
      end
      default: begin
        sel_d   = SEL_INIT;
        state_d = S_INIT;
      end
    endcase

    // Entry to ERR drops all pending work; while in ERR, requests are ignored.
    if (state_d == S_ERR && state_q != S_ERR) begin
      err_d     = 1'b1;
      sel_d     = SEL_NONE;
      pend_wr_d = 1'b0;
      pend_rd_d = 1'b0;
    end else if (state_q != S_ERR) begin
      pend_wr_d = (pend_wr_q && !clr_wr) || bus.wr_req;
      pend_rd_d = (pend_rd_q && !clr_rd) || bus.rd_req;
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != cnt_lim) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    // Engine resets lag sel by one cycle, so a deselected engine always sees a reset cycle.
    init_rst_n_d = (sel_q == SEL_INIT);
    wr_rst_n_d   = (sel_q == SEL_WR);
    rd_rst_n_d   = (sel_q == SEL_RD);
    write_seq_d  = (state_d == S_WR_SEQ);
    read_seq_d   = (state_d == S_RD_SEQ);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SD_CK or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      sel_q        <= SEL_INIT;
      cnt_q        <= '0;
      pend_wr_q    <= 1'b0;
      pend_rd_q    <= 1'b0;
      last_wr_q    <= 1'b0;
      init_rst_n_q <= 1'b0;
      wr_rst_n_q   <= 1'b0;
      rd_rst_n_q   <= 1'b0;
      write_seq_q  <= 1'b0;
      read_seq_q   <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      last_wr_q    <= last_wr_d;
      init_rst_n_q <= init_rst_n_d;
      wr_rst_n_q   <= wr_rst_n_d;
      rd_rst_n_q   <= rd_rst_n_d;
      write_seq_q  <= write_seq_d;
      read_seq_q   <= read_seq_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      err_q        <= err_d;
    end
  end

  // Engines drive their pins on negedge, so the mux stays combinational on registered sel.
  always_comb begin
    bus.SD_CSn  = 1'b1;
    bus.SD_MOSI = 1'b1;
    case (sel_q)
      SEL_INIT: begin bus.SD_CSn = bus.init_CSn; bus.SD_MOSI = bus.init_MOSI; end
      SEL_WR:   begin bus.SD_CSn = bus.wr_CSn;   bus.SD_MOSI = bus.wr_MOSI;   end
      SEL_RD:   begin bus.SD_CSn = bus.rd_CSn;   bus.SD_MOSI = bus.rd_MOSI;   end
      default:  begin bus.SD_CSn = 1'b1;         bus.SD_MOSI = 1'b1;          end
    endcase
  end

  assign bus.init_rst_n = init_rst_n_q;
  assign bus.wr_rst_n   = wr_rst_n_q;
  assign bus.rd_rst_n   = rd_rst_n_q;
  assign bus.write_seq  = write_seq_q;
  assign bus.read_seq   = read_seq_q;
  assign bus.init_done  = init_done_q;
  assign bus.busy       = busy_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_sd_xfer_sched.sv
// Bench for sd_xfer_sched: emulated init/write/read engines, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_sd_xfer_sched;
  localparam int INIT_TO = 65535;
  localparam int XFER_TO = 4095;

  logic SD_CK = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  sd_xfer_sched_if bus ();

  sd_xfer_sched #(.INIT_TO(INIT_TO), .XFER_TO(XFER_TO), .CNT_W(16)) dut (
    .SD_CK (SD_CK),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 SD_CK = ~SD_CK;
  always @(posedge SD_CK) cyc <= cyc + 1;

  // Stimulus and engine-emulation drive values.
  logic wr_req = 0, rd_req = 0, err_clr = 0, init_o = 0;
  logic init_cs_r = 0, init_mosi_r = 0, wr_cs_r = 0, wr_mosi_r = 0, rd_cs_r = 0, rd_mosi_r = 0;
  logic wr_ok_r = 0, rd_ok_r = 0, wr_run = 0, rd_run = 0;
  int   wr_lat = 30, rd_lat = 30, wr_cnt = 0, rd_cnt = 0;

  assign bus.wr_req    = wr_req;
  assign bus.rd_req    = rd_req;
  assign bus.err_clr   = err_clr;
  assign bus.init_o    = init_o;
  assign bus.init_CSn  = bus.init_rst_n ? init_cs_r : 1'b1;
  assign bus.init_MOSI = init_mosi_r;
  assign bus.wr_CSn    = bus.wr_rst_n ? wr_cs_r : 1'b1;
  assign bus.wr_MOSI   = wr_mosi_r;
  assign bus.rd_CSn    = bus.rd_rst_n ? rd_cs_r : 1'b1;
  assign bus.rd_MOSI   = rd_mosi_r;
  assign bus.wr_ok     = wr_ok_r;
  assign bus.rd_ok     = rd_ok_r;

  // Engines: random pin activity, start on a negedge-sampled strobe, sticky ok after a latency.
  always @(negedge SD_CK) begin
    init_cs_r   = 1'($urandom);
    init_mosi_r = 1'($urandom);
    wr_cs_r     = 1'($urandom);
    wr_mosi_r   = 1'($urandom);
    rd_cs_r     = 1'($urandom);
    rd_mosi_r   = 1'($urandom);
    if (!bus.wr_rst_n) begin
      wr_run = 0; wr_cnt = 0; wr_ok_r = 0;
    end else if (bus.write_seq && !wr_run) begin
      wr_run = 1; wr_cnt = 0;
    end else if (wr_run && !wr_ok_r) begin
      wr_cnt++;
      if (wr_cnt >= wr_lat) wr_ok_r = 1;
    end
    if (!bus.rd_rst_n) begin
      rd_run = 0; rd_cnt = 0; rd_ok_r = 0;
    end else if (bus.read_seq && !rd_run) begin
      rd_run = 1; rd_cnt = 0;
    end else if (rd_run && !rd_ok_r) begin
      rd_cnt++;
      if (rd_cnt >= rd_lat) rd_ok_r = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: kind 0=none 1=write 2=read; age counts cycles since ARM.
  bit m_init, m_err, m_idone, m_last_wr, m_pw, m_pr, m_wdone, m_rdone;
  bit m_rn_i, m_rn_w, m_rn_r;
  int m_kind, m_age, m_icnt;

  function automatic int model_sel();
    if (m_err)       return 0;
    if (m_init)      return 1;
    if (m_kind == 1) return 2;
    if (m_kind == 2) return 3;
    return 0;
  endfunction

  task automatic model_step(input bit s_rst, s_wr, s_rd, s_clr, s_io, s_wok, s_rok);
    int ps;
    bit to_err, cw, cr, was_err, ok;
    if (s_rst) begin
      m_init = 1; m_err = 0; m_idone = 0; m_last_wr = 0; m_pw = 0; m_pr = 0;
      m_kind = 0; m_age = 0; m_icnt = 0; m_wdone = 0; m_rdone = 0;
      m_rn_i = 0; m_rn_w = 0; m_rn_r = 0;
      return;
    end
    ps = model_sel();
    to_err = 0; cw = 0; cr = 0; was_err = m_err;
    m_wdone = 0; m_rdone = 0;
    m_rn_i = (ps == 1); m_rn_w = (ps == 2); m_rn_r = (ps == 3);
    if (m_err) begin
      if (s_clr) begin m_err = 0; m_idone = 0; m_init = 1; m_icnt = 0; end
    end else if (m_init) begin
      if (s_io) begin m_init = 0; m_idone = 1; end
      else if (m_icnt == INIT_TO) to_err = 1;
      else m_icnt++;
    end else if (m_kind != 0) begin
      if (m_age < 2) m_age++;
      else begin
        ok = (m_kind == 1) ? s_wok : s_rok;
        if (ok) begin
          if (m_kind == 1) begin m_wdone = 1; cw = 1; m_last_wr = 1; end
          else begin m_rdone = 1; cr = 1; m_last_wr = 0; end
          m_kind = 0;
        end else if (m_age - 2 == XFER_TO) to_err = 1;
        else m_age++;
      end
    end else begin
      if (m_pw && (!m_pr || !m_last_wr)) begin m_kind = 1; m_age = 0; end
      else if (m_pr) begin m_kind = 2; m_age = 0; end
    end
    if (to_err) begin
      m_err = 1; m_init = 0; m_kind = 0; m_pw = 0; m_pr = 0;
    end else if (!was_err) begin
      m_pw = (m_pw && !cw) || s_wr;
      m_pr = (m_pr && !cr) || s_rd;
    end
  endtask

  always @(posedge SD_CK) begin : cmp
    logic s_rst, s_wr, s_rd, s_clr, s_io, s_wok, s_rok, ecs, emo;
    int es;
    s_rst = rst; s_wr = wr_req; s_rd = rd_req; s_clr = err_clr;
    s_io = init_o; s_wok = bus.wr_ok; s_rok = bus.rd_ok;
    #1;
    model_step(s_rst, s_wr, s_rd, s_clr, s_io, s_wok, s_rok);
    es = model_sel();
    case (es)
      1:       begin ecs = bus.init_CSn; emo = bus.init_MOSI; end
      2:       begin ecs = bus.wr_CSn;   emo = bus.wr_MOSI;   end
      3:       begin ecs = bus.rd_CSn;   emo = bus.rd_MOSI;   end
      default: begin ecs = 1'b1;         emo = 1'b1;          end
    endcase
    check("busy",       bus.busy,       m_err || m_init || (m_kind != 0));
    check("err",        bus.err,        m_err);
    check("init_done",  bus.init_done,  m_idone);
    check("write_seq",  bus.write_seq,  (m_kind == 1) && (m_age == 1));
    check("read_seq",   bus.read_seq,   (m_kind == 2) && (m_age == 1));
    check("wr_done",    bus.wr_done,    m_wdone);
    check("rd_done",    bus.rd_done,    m_rdone);
    check("init_rst_n", bus.init_rst_n, m_rn_i);
    check("wr_rst_n",   bus.wr_rst_n,   m_rn_w);
    check("rd_rst_n",   bus.rd_rst_n,   m_rn_r);
    check("SD_CSn",     bus.SD_CSn,     ecs);
    check("SD_MOSI",    bus.SD_MOSI,    emo);
  end

  // Directed stimulus: act and sample mid-cycle, one time unit after the negedge.
  task automatic step();
    @(negedge SD_CK);
    #1;
  endtask

  task automatic pulse(input bit w, input bit r);
    step(); wr_req = w; rd_req = r;
    step(); wr_req = 0; rd_req = 0;
  endtask

  task automatic wait_done(input int lim, output int which);
    which = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (bus.wr_done) begin which = 1; break; end
      if (bus.rd_done) begin which = 2; break; end
    end
  endtask

  task automatic wait_sig_seq(input bit rd, input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (rd ? bus.read_seq : bus.write_seq) begin seen = 1; break; end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int which, s, nwr, nrd, nseq;
    bit seen;

    while (cyc < 3) step();
    check("rst_busy", bus.busy, 1);
    check("rst_init_rst_n", bus.init_rst_n, 0);
    check("rst_SD_CSn", bus.SD_CSn, 1);
    check("rst_err", bus.err, 0);
    while (cyc < 5) step();
    rst = 0;
    check("init_rst_n_held", bus.init_rst_n, 0);
    step();
    check("init_rst_n_release", bus.init_rst_n, 1);

    while (cyc < 20) step();
    init_o = 1;
    check("init_done_c20", bus.init_done, 0);
    step();
    check("init_done_c21", bus.init_done, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_SD_CSn", bus.SD_CSn, 1);
    check("idle_SD_MOSI", bus.SD_MOSI, 1);
    check("idle_wr_rst_n", bus.wr_rst_n, 0);
    check("idle_rd_rst_n", bus.rd_rst_n, 0);

    // err_clr outside ERR has no effect.
    step(); err_clr = 1; step(); err_clr = 0;
    repeat (3) step();
    check("clr_ignored_init_done", bus.init_done, 1);

    // First tie: write wins since last resets to read.
    wr_lat = 30; rd_lat = 30;
    pulse(1, 1);
    wait_done(200, which);
    check("tieA_first", which, 1);
    wait_done(200, which);
    check("tieA_second", which, 2);

    // Single write with a 1700-cycle engine latency.
    repeat (3) step();
    wr_lat = 1700;
    pulse(1, 0);
    wait_sig_seq(0, 10, seen);
    check("wr_seq_seen", seen, 1);
    s = cyc;
    check("wr_seq_pin_follow", bus.SD_CSn, bus.wr_CSn);
    step();
    check("wr_seq_one_cycle", bus.write_seq, 0);
    wait_done(2000, which);
    check("wr_done_seen", which, 1);
    check("wr_done_gap", cyc - s, 1701);
    check("wr_done_busy", bus.busy, 0);
    step();
    check("wr_done_pulse", bus.wr_done, 0);
    check("wr_rst_after", bus.wr_rst_n, 0);

    // Second tie after a write: read goes first.
    wr_lat = 30;
    pulse(1, 1);
    wait_done(200, which);
    check("tieB_first", which, 2);
    wait_done(200, which);
    check("tieB_second", which, 1);

    // Three read requests during a long write merge into one read.
    repeat (3) step();
    wr_lat = 200; rd_lat = 30;
    pulse(1, 0);
    repeat (5) step();
    pulse(0, 1); step(); pulse(0, 1); step(); pulse(0, 1);
    nwr = 0; nrd = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.wr_done) nwr++;
      if (bus.rd_done) nrd++;
    end
    check("merge_wr_count", nwr, 1);
    check("merge_rd_count", nrd, 1);

    // Write that never completes times out into ERR.
    wr_lat = 1000000;
    pulse(1, 0);
    wait_sig_seq(0, 10, seen);
    check("to_seq_seen", seen, 1);
    s = cyc;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (bus.err) break;
    end
    check("to_err_set", bus.err, 1);
    check("to_err_gap", cyc - s, 4097);
    check("to_SD_CSn", bus.SD_CSn, 1);
    check("to_busy", bus.busy, 1);
    pulse(1, 0);
    repeat (5) step();
    check("to_wr_rst_n", bus.wr_rst_n, 0);
    check("to_req_ignored", bus.write_seq, 0);
    init_o = 0;
    step(); err_clr = 1; step(); err_clr = 0;
    repeat (5) step();
    check("clr_err", bus.err, 0);
    check("clr_init_done", bus.init_done, 0);
    check("clr_busy", bus.busy, 1);
    init_o = 1;
    step(); step();
    check("reinit_done", bus.init_done, 1);
    check("reinit_idle", bus.busy, 0);

    // Reset in the middle of a read.
    wr_lat = 30; rd_lat = 100;
    pulse(0, 1);
    wait_sig_seq(1, 10, seen);
    check("rd_seq_seen", seen, 1);
    repeat (5) step();
    rst = 1;
    #1;
    check("rst_async_SD_CSn", bus.SD_CSn, 1);
    check("rst_async_read_seq", bus.read_seq, 0);
    step();
    check("rst_SD_CSn_next", bus.SD_CSn, 1);
    check("rst_rd_done", bus.rd_done, 0);
    step();
    rst = 0;
    nrd = 0; nseq = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.rd_done) nrd++;
      if (bus.read_seq) nseq++;
    end
    check("rst_no_rd_done", nrd, 0);
    check("rst_pend_lost", nseq, 0);
    check("rst_reinit", bus.init_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
